// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM stage: default widths, control-bit positions
// and the packed entry carried through the skid buffer.
package ex_mem_pkg;

   localparam int DW_DEF = 32;
   localparam int RW_DEF = 5;

   localparam int CTRL_REG_WR = 4;
   localparam int CTRL_MEM_RD = 3;
   localparam int CTRL_MEM_WR = 2;
   localparam int CTRL_BR     = 1;
   localparam int CTRL_BNE    = 0;

   typedef struct packed {
      logic [DW_DEF-1:0] result;
      logic              cout;
      logic [RW_DEF-1:0] rd;
      logic [DW_DEF-1:0] store_data;
      logic [4:0]        ctrl;
   } ex_mem_entry_t;

endpackage

// File: rtl/ex_mem_skid.sv
// Generic two-entry skid buffer with flush. The main entry drives the outputs;
// the skid entry catches one transfer while the main entry is stalled.
module ex_mem_skid #(
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_data,
   output logic          in_take,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] out_data
);

   logic          main_vld_q, main_vld_d;
   logic          skid_vld_q, skid_vld_d;
   logic          in_ready_q, in_ready_d;
   logic [PW-1:0] main_q, main_d;
   logic [PW-1:0] skid_q, skid_d;
   logic          drain;

   assign drain   = main_vld_q & out_ready;
   assign in_take = in_valid & in_ready_q & ~flush;

   always_comb begin
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      main_d     = main_q;
      skid_d     = skid_q;
      // Flush only kills the valid bits; payload keeps its last value.
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (drain && skid_vld_q) begin
         main_d     = skid_q;
         skid_vld_d = 1'b0;
      end else if (in_take && (!main_vld_q || drain)) begin
         main_d     = in_data;
         main_vld_d = 1'b1;
      end else if (in_take) begin
         skid_d     = in_data;
         skid_vld_d = 1'b1;
      end else if (drain) begin
         main_vld_d = 1'b0;
      end
      in_ready_d = ~skid_vld_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         in_ready_q <= in_ready_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_vld_q;
   assign out_data  = main_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: buffers ALU results through a two-entry skid buffer and
// resolves branches at accept time. Define EX_MEM_FWD_EN to add bypass outputs.
module ex_mem_stage
   import ex_mem_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] alu_s,
   input  logic          alu_cout,
   input  logic          alu_zero,
   input  logic [RW-1:0] rd,
   input  logic [DW-1:0] store_data,
   input  logic [4:0]    ctrl,
   input  logic [DW-1:0] br_target,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_result,
   output logic          out_cout,
   output logic [RW-1:0] out_rd,
   output logic [DW-1:0] out_store_data,
   output logic [4:0]    out_ctrl,
   output logic          br_taken,
   output logic [DW-1:0] br_pc
`ifdef EX_MEM_FWD_EN
   ,
   output logic          fwd_valid,
   output logic [RW-1:0] fwd_rd,
   output logic [DW-1:0] fwd_data
`endif
);

   // Entry widths come from the package; DW/RW must stay at the package defaults.
   ex_mem_entry_t in_entry;
   ex_mem_entry_t out_entry;
   logic          in_take;
   logic          br_taken_q, br_taken_d;
   logic [DW-1:0] br_pc_q, br_pc_d;

   always_comb begin
      in_entry.result     = alu_s;
      in_entry.cout       = alu_cout;
      in_entry.rd         = rd;
      in_entry.store_data = store_data;
      in_entry.ctrl       = ctrl;
   end

   ex_mem_skid #(
      .PW($bits(ex_mem_entry_t))
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_entry),
      .in_take   (in_take),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_entry)
   );

   // Branches redirect when accepted, independent of when they drain.
   always_comb begin
      br_taken_d = 1'b0;
      br_pc_d    = br_pc_q;
      if (in_take && ctrl[CTRL_BR] && (alu_zero ^ ctrl[CTRL_BNE])) begin
         br_taken_d = 1'b1;
         br_pc_d    = br_target;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_taken_q <= 1'b0;
         br_pc_q    <= '0;
      end else begin
         br_taken_q <= br_taken_d;
         br_pc_q    <= br_pc_d;
      end
   end

   assign br_taken       = br_taken_q;
   assign br_pc          = br_pc_q;
   assign out_result     = out_entry.result;
   assign out_cout       = out_entry.cout;
   assign out_rd         = out_entry.rd;
   assign out_store_data = out_entry.store_data;
   assign out_ctrl       = out_entry.ctrl;

`ifdef EX_MEM_FWD_EN
   // Loads are excluded: their value only exists after the memory stage.
   assign fwd_valid = out_valid & out_entry.ctrl[CTRL_REG_WR] & ~out_entry.ctrl[CTRL_MEM_RD]
                      & (out_entry.rd != '0);
   assign fwd_rd    = out_entry.rd;
   assign fwd_data  = out_entry.result;
`endif

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the 32-bit ALU: registers the ALU result (s, cout, zero_detect) together with instruction control bits.
- Two-entry skid buffer decouples execute from memory with a valid/ready handshake.
- Resolves conditional branches from the ALU zero flag and emits a one-cycle redirect pulse.
- Supports pipeline flush.

Parameters:
- DW, 32, datapath width (result, store data, branch target)
- RW, 5, destination register index width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute stage presents a valid instruction
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- alu_s  in  DW  ALU result
- alu_cout  in  1  ALU carry out
- alu_zero  in  1  ALU zero_detect
- rd  in  RW  destination register
- store_data  in  DW  data for stores
- ctrl  in  5  {reg_wr, mem_rd, mem_wr, is_branch, branch_ne}
- br_target  in  DW  precomputed branch target
- flush  in  1  kill all buffered and incoming instructions
- out_valid  out  1  main entry valid
- out_ready  in  1  memory stage accepts
- out_result / out_cout / out_rd / out_store_data / out_ctrl  out  DW/1/RW/DW/5  registered payload (zero flag not forwarded)
- br_taken  out  1  one-cycle branch redirect pulse
- br_pc  out  DW  redirect target, valid when br_taken=1

Behaviour:
- Reset (async, rst_n=0): out_valid=0, skid_valid=0, in_ready=1, br_taken=0, br_pc=0, all payload outputs 0.
- Accept: in_valid & in_ready at an edge. Drain: out_valid & out_ready at an edge.
- Storage: main register (drives outputs) and skid register.
  - Empty main, or main draining: the accepted entry goes to main (latency 1 cycle, input to out_valid).
  - Main holding and not draining: the accepted entry goes to skid, and in_ready drops the next cycle.
  - Main drains while skid is valid: skid moves to main and skid_valid clears. A simultaneous accept is impossible because in_ready=0.
- Ordering: strict FIFO. No entry is dropped or duplicated.
- Payload is stable while out_valid & !out_ready (AXI-style hold). Payload is don't-care when out_valid=0, but the implementation holds its last value.
- Branch resolution on accept of an entry with is_branch=1:
  - condition = alu_zero ^ branch_ne (beq when branch_ne=0, bne when branch_ne=1).
  - If the condition is true, next cycle br_taken=1 for exactly one cycle and br_pc=br_target.
  - br_pc holds its value otherwise.
  - Resolution happens at accept, not at drain. A branch stuck in the buffer has already redirected.
- Flush (priority over everything):
  - At the edge, out_valid and skid_valid clear and in_ready becomes 1.
  - Any input offered in the same cycle is discarded and produces no br_taken.
  - br_taken from an accept in the previous cycle still pulses; it is registered before the flush.
  - Payload registers are not cleared.
- Simultaneous accept and drain with main valid and skid empty: the new entry replaces main; out_valid stays 1.
- cout passes through untouched. Branch entries still propagate to out_* (reg_wr is normally 0); the stage does not suppress them.
- Reset mid-operation: all buffered entries are lost and no pulse is generated.

Optional Feature:
- Macro EX_MEM_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_rd (RW) and fwd_data (DW), combinationally mirroring the main entry for the bypass network.
  - fwd_valid = out_valid & out_ctrl.reg_wr & !out_ctrl.mem_rd & (out_rd != 0).
  - fwd_rd = out_rd.
  - fwd_data = out_result.
- Not defined: these ports do not exist; no forwarding logic is generated.

Decomposition:
- Package ex_mem_pkg holds:
  - DW and RW defaults.
  - The ctrl bit indices: CTRL_REG_WR=4, CTRL_MEM_RD=3, CTRL_MEM_WR=2, CTRL_BR=1, CTRL_BNE=0.
  - A packed payload struct type used for both main and skid entries.
- One natural sub-module: ex_mem_skid, a generic two-entry skid buffer over the packed payload with flush.
- Branch resolution stays in the top module.

Test Plan:
- Reset then single accept, alu_s=0x0000_00FF, rd=3, out_ready=1: out_valid=1 the next cycle with out_result=0xFF and out_rd=3; out_valid=0 the cycle after.
- Back-pressure: out_ready=0 while accepting A=0x11, then B=0x22:
  - in_ready=0 after B.
  - Release out_ready: drain order is 0x11 then 0x22, with in_ready=1 after the first drain.
- beq taken: is_branch=1, branch_ne=0, alu_zero=1, br_target=0x0000_0400 → br_taken=1 for exactly one cycle with br_pc=0x400. Same stimulus with alu_zero=0 → br_taken stays 0.
- bne with alu_zero=0, target 0x800 accepted in the same cycle flush=1 → entry discarded, br_taken=0, out_valid=0, in_ready=1.
- Full buffer (2 entries, out_ready=0) then flush=1 → next cycle out_valid=0, in_ready=1; a later accept of 0x33 emerges alone.
- With EX_MEM_FWD_EN defined: main entry with reg_wr=1, rd=0 → fwd_valid=0; same entry with rd=7 and result 0xDEAD_BEEF → fwd_valid=1, fwd_rd=7, fwd_data=0xDEAD_BEEF.
